sgd_train_sched: RTL and testbench

- Training scheduler for the SGD datapath. It shares the single-port dataset RAM between the host loader and the training engine.
- It sequences one weight-load row, then cfg_epoch passes over data points 1..cfg_dp. Each RAM row is delivered to the engine over a valid/ready handshake.
- It handles pause/abort and reports progress and completion.
- Sits between the host config/load interface, the dataset RAM and the SGD engine.

---
 rtl/sgd_pkg.sv | 23 ++
 rtl/sgd_ram_mux.sv | 38 +++
 rtl/sgd_train_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sgd_train_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared constants for the SGD training scheduler: row geometry, weight row
// location and the scheduler state encoding.
package sgd_pkg;

  localparam int unsigned MAX_FEATURES    = 15;
  localparam int unsigned FEAT_LEN        = 16;
  // One RAM row holds MAX_FEATURES features plus the label/bias slot.
  localparam int unsigned SGD_DATA_WIDTH  = FEAT_LEN * (MAX_FEATURES + 1);
  localparam int unsigned WEIGHT_ROW_ADDR = 0;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WREQ   = 4'd1,
    ST_WCAP   = 4'd2,
    ST_WXFER  = 4'd3,
    ST_RREQ   = 4'd4,
    ST_RCAP   = 4'd5,
    ST_RXFER  = 4'd6,
    ST_PAUSED = 4'd7,
    ST_DONE   = 4'd8
  } sched_state_e;

endpackage

// File: rtl/sgd_ram_mux.sv
// Single-port dataset RAM arbiter: passes the host write port through when
// the host owns the RAM, otherwise drives the scheduler read address.
//   host_own_i    : 1 = host owns the RAM port
//   h_we_i/h_addr_i/h_wdata_i : host write port
//   sched_addr_i  : scheduler read address
//   ram_*_o       : RAM port
//   h_busy_o      : host writes are being dropped
module sgd_ram_mux
  import sgd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = SGD_DATA_WIDTH
) (
  input  logic                  host_own_i,
  input  logic                  h_we_i,
  input  logic [ADDR_WIDTH-1:0] h_addr_i,
  input  logic [DATA_WIDTH-1:0] h_wdata_i,
  input  logic [ADDR_WIDTH-1:0] sched_addr_i,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic                  h_busy_o
);

  always_comb begin
    ram_we_o    = 1'b0;
    ram_addr_o  = sched_addr_i;
    ram_wdata_o = '0;
    h_busy_o    = 1'b1;
    if (host_own_i) begin
      ram_we_o    = h_we_i;
      ram_addr_o  = h_addr_i;
      ram_wdata_o = h_wdata_i;
      h_busy_o    = 1'b0;
    end
  end

endmodule

// File: rtl/sgd_train_sched.sv
// Training scheduler: streams the weight row then cfg_epoch passes over data
// rows 1..cfg_dp from the shared dataset RAM to the SGD engine over a
// valid/ready handshake, with pause at row boundaries and abort.
//   CLK, RST (sync, active-high)
//   start/pause/abort, cfg_dp/cfg_epoch : run control
//   h_we/h_addr/h_wdata, h_busy         : host load port
//   ram_*                               : dataset RAM port (1-cycle read)
//   dp_valid/dp_data/dp_wload/dp_last, dp_ready : engine stream
//   epoch_cnt/dp_cnt/busy/done          : progress and status
module sgd_train_sched
  import sgd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = SGD_DATA_WIDTH,
  parameter int unsigned EPOCH_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic [ADDR_WIDTH-1:0]  cfg_dp,
  input  logic [EPOCH_WIDTH-1:0] cfg_epoch,
  input  logic                   h_we,
  input  logic [ADDR_WIDTH-1:0]  h_addr,
  input  logic [DATA_WIDTH-1:0]  h_wdata,
  output logic                   h_busy,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_we,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata,
  output logic                   dp_valid,
  output logic [DATA_WIDTH-1:0]  dp_data,
  output logic                   dp_wload,
  output logic                   dp_last,
  input  logic                   dp_ready,
  output logic [EPOCH_WIDTH-1:0] epoch_cnt,
  output logic [ADDR_WIDTH-1:0]  dp_cnt,
  output logic                   busy,
  output logic                   done
);

  sched_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cfg_dp_q, cfg_dp_d;
  logic [EPOCH_WIDTH-1:0]  cfg_epoch_q, cfg_epoch_d;
  logic [ADDR_WIDTH-1:0]   dp_cnt_q, dp_cnt_d;
  logic [EPOCH_WIDTH-1:0]  epoch_cnt_q, epoch_cnt_d;
  logic [EPOCH_WIDTH-1:0]  epoch_inc;
  logic [EPOCH_WIDTH-1:0]  last_epoch_inc;
  logic [DATA_WIDTH-1:0]   dp_data_q, dp_data_d;
  logic                    dp_valid_q, dp_valid_d;
  logic                    dp_wload_q, dp_wload_d;
  logic                    dp_last_q, dp_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   sched_addr;
  logic                    host_own;

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cfg_dp_q    <= '0;
      cfg_epoch_q <= '0;
      dp_cnt_q    <= '0;
      epoch_cnt_q <= '0;
      dp_data_q   <= '0;
      dp_valid_q  <= 1'b0;
      dp_wload_q  <= 1'b0;
      dp_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_dp_q    <= cfg_dp_d;
      cfg_epoch_q <= cfg_epoch_d;
      dp_cnt_q    <= dp_cnt_d;
      epoch_cnt_q <= epoch_cnt_d;
      dp_data_q   <= dp_data_d;
      dp_valid_q  <= dp_valid_d;
      dp_wload_q  <= dp_wload_d;
      dp_last_q   <= dp_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, counter advance and registered stream flags.
  always_comb begin
    state_d        = state_q;
    cfg_dp_d       = cfg_dp_q;
    cfg_epoch_d    = cfg_epoch_q;
    dp_cnt_d       = dp_cnt_q;
    epoch_cnt_d    = epoch_cnt_q;
    dp_data_d      = dp_data_q;
    sched_addr     = ADDR_WIDTH'(WEIGHT_ROW_ADDR);
    epoch_inc      = epoch_cnt_q + EPOCH_WIDTH'(1);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cfg_dp_d    = cfg_dp;
          cfg_epoch_d = cfg_epoch;
          dp_cnt_d    = '0;
          epoch_cnt_d = '0;
          state_d     = ((cfg_dp == '0) || (cfg_epoch == '0)) ? ST_DONE : ST_WREQ;
        end
      end
      ST_WREQ: begin
        sched_addr = ADDR_WIDTH'(WEIGHT_ROW_ADDR);
        state_d    = ST_WCAP;
      end
      ST_WCAP: begin
        dp_data_d = ram_rdata;
        state_d   = ST_WXFER;
      end
      ST_WXFER: begin
        if (dp_ready) begin
          dp_cnt_d = ADDR_WIDTH'(1);
          state_d  = pause ? ST_PAUSED : ST_RREQ;
        end
      end
      ST_RREQ: begin
        sched_addr = dp_cnt_q;
        state_d    = ST_RCAP;
      end
      ST_RCAP: begin
        sched_addr = dp_cnt_q;
        dp_data_d  = ram_rdata;
        state_d    = ST_RXFER;
      end
      ST_RXFER: begin
        if (dp_ready) begin
          if (dp_cnt_q == cfg_dp_q) begin
            dp_cnt_d    = ADDR_WIDTH'(1);
            epoch_cnt_d = epoch_inc;
            // Completion beats a pending pause on the final row.
            if (epoch_inc == cfg_epoch_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = pause ? ST_PAUSED : ST_RREQ;
            end
          end else begin
            dp_cnt_d = dp_cnt_q + ADDR_WIDTH'(1);
            state_d  = pause ? ST_PAUSED : ST_RREQ;
          end
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          state_d = ST_RREQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort freezes counters for inspection and drops the stream.
    if (abort) begin
      state_d     = ST_IDLE;
      cfg_dp_d    = cfg_dp_q;
      cfg_epoch_d = cfg_epoch_q;
      dp_cnt_d    = dp_cnt_q;
      epoch_cnt_d = epoch_cnt_q;
    end

    last_epoch_inc = epoch_cnt_d + EPOCH_WIDTH'(1);
    dp_valid_d     = (state_d == ST_WXFER) || (state_d == ST_RXFER);
    dp_wload_d     = (state_d == ST_WXFER);
    dp_last_d      = (state_d == ST_RXFER) && (dp_cnt_d == cfg_dp_d) &&
                     (last_epoch_inc == cfg_epoch_d);
    busy_d         = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d         = (state_d == ST_DONE);
  end

  assign host_own = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_PAUSED);

  sgd_ram_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram_mux (
    .host_own_i   (host_own),
    .h_we_i       (h_we),
    .h_addr_i     (h_addr),
    .h_wdata_i    (h_wdata),
    .sched_addr_i (sched_addr),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .h_busy_o     (h_busy)
  );

  assign dp_valid  = dp_valid_q;
  assign dp_data   = dp_data_q;
  assign dp_wload  = dp_wload_q;
  assign dp_last   = dp_last_q;
  assign epoch_cnt = epoch_cnt_q;
  assign dp_cnt    = dp_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sgd_train_sched.sv
// Bench for sgd_train_sched: RAM model, host loader, and a row-sequence
// reference built from the run configuration.
module tb_sgd_train_sched;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 256;
  localparam int unsigned EW = 8;

  logic          CLK, RST, start, pause, abort;
  logic [AW-1:0] cfg_dp;
  logic [EW-1:0] cfg_epoch;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          dp_valid;
  logic [DW-1:0] dp_data;
  logic          dp_wload, dp_last, dp_ready;
  logic [EW-1:0] epoch_cnt;
  logic [AW-1:0] dp_cnt;
  logic          busy, done;

  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:15];

  int errors = 0;
  int checks = 0;

  sgd_train_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EPOCH_WIDTH(EW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pause(pause), .abort(abort),
    .cfg_dp(cfg_dp), .cfg_epoch(cfg_epoch),
    .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_busy(h_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_wload(dp_wload), .dp_last(dp_last),
    .dp_ready(dp_ready), .epoch_cnt(epoch_cnt), .dp_cnt(dp_cnt),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single-port RAM, 1-cycle read latency.
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic host_write(input int a, input logic [DW-1:0] d);
    h_we = 1'b1; h_addr = AW'(a); h_wdata = d;
    @(posedge CLK); #1;
    h_we = 1'b0; h_addr = '0;
    ref_mem[a] = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_b({pfx, "_dp_valid"}, dp_valid, 1'b0);
    check_b({pfx, "_dp_wload"}, dp_wload, 1'b0);
    check_b({pfx, "_dp_last"},  dp_last,  1'b0);
    check_w({pfx, "_dp_data"},  dp_data,  '0);
    check_i({pfx, "_epoch_cnt"}, int'(epoch_cnt), 0);
    check_i({pfx, "_dp_cnt"},    int'(dp_cnt), 0);
    check_b({pfx, "_busy"},   busy,   1'b0);
    check_b({pfx, "_done"},   done,   1'b0);
    check_b({pfx, "_h_busy"}, h_busy, 1'b0);
    check_b({pfx, "_ram_we"}, ram_we, 1'b0);
    check_i({pfx, "_ram_addr"}, int'(ram_addr), 0);
  endtask

  // Runs one training job and compares every delivered row with the row
  // sequence implied by (d, e): weight row, then e passes over rows 1..d.
  task automatic run_sched(input int d, input int e, input bit rnd, input int stall_idx,
                           input int pause_idx, input int hwe_idx, input int abort_after);
    int exp_addr[$];
    bit exp_wl[$];
    bit exp_last[$];
    int idx, cyc, prev_hs, stall_left, n, k;
    bit paused, abort_pend, hwe_done, plain;
    logic [DW-1:0] held;

    exp_addr.push_back(0); exp_wl.push_back(1'b1); exp_last.push_back(1'b0);
    for (int ep = 0; ep < e; ep++) begin
      for (int p = 1; p <= d; p++) begin
        exp_addr.push_back(p);
        exp_wl.push_back(1'b0);
        exp_last.push_back((ep == e - 1) && (p == d));
      end
    end
    n = exp_addr.size();
    plain = !rnd && (stall_idx < 0) && (pause_idx < 0);
    idx = 0; cyc = 0; prev_hs = 0; stall_left = 5;
    paused = 1'b0; abort_pend = 1'b0; hwe_done = 1'b0; held = '0;

    cfg_dp = AW'(d); cfg_epoch = EW'(e); start = 1'b1; dp_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    // Configuration changes after start must not affect the run.
    cfg_dp = AW'($urandom_range(1, 9)); cfg_epoch = EW'($urandom_range(1, 9));
    check_b("start_busy", busy, 1'b1);
    check_b("start_done_clr", done, 1'b0);

    while (cyc < 500) begin
      if (abort_pend) begin
        abort = 1'b1;
        @(posedge CLK); #1;
        abort = 1'b0;
        k = abort_after - 1;
        check_b("abort_valid", dp_valid, 1'b0);
        check_b("abort_done", done, 1'b0);
        check_b("abort_busy", busy, 1'b0);
        check_i("abort_dp_cnt", int'(dp_cnt), (k % d) + 1);
        check_i("abort_epoch", int'(epoch_cnt), k / d);
        return;
      end
      if (paused) begin
        check_b("pause_h_busy", h_busy, 1'b0);
        check_b("pause_valid", dp_valid, 1'b0);
        h_we = 1'b1; h_addr = AW'(2); h_wdata = rand_row();
        ref_mem[2] = h_wdata;
        @(posedge CLK); #1;
        h_we = 1'b0; h_addr = '0; pause = 1'b0; paused = 1'b0; cyc++;
      end
      if (dp_valid) begin
        if (idx >= n) begin
          check_i("extra_row", idx, n - 1);
          break;
        end
        if (idx == stall_idx && stall_left > 0) begin
          if (stall_left == 5) held = dp_data;
          else check_w("stall_hold", dp_data, held);
          dp_ready = 1'b0;
          stall_left--;
        end else if (rnd) begin
          dp_ready = ($urandom_range(0, 2) != 0);
        end else begin
          dp_ready = 1'b1;
        end
        if (idx == hwe_idx && !hwe_done) begin
          hwe_done = 1'b1;
          h_we = 1'b1; h_addr = AW'(1); h_wdata = ~ref_mem[1];
          #1;
          check_b("hwe_ram_we", ram_we, 1'b0);
          check_b("hwe_h_busy", h_busy, 1'b1);
        end
        if (dp_ready) begin
          check_w($sformatf("row%0d_data", idx), dp_data, ref_mem[exp_addr[idx]]);
          check_b($sformatf("row%0d_wload", idx), dp_wload, exp_wl[idx]);
          check_b($sformatf("row%0d_last", idx), dp_last, exp_last[idx]);
          if (plain) check_i($sformatf("row%0d_gap", idx), (idx == 0) ? cyc : cyc - prev_hs,
                             (idx == 0) ? 2 : 3);
          prev_hs = cyc;
          if (idx == pause_idx) begin
            pause = 1'b1;
            paused = 1'b1;
          end
          idx++;
          if (idx == abort_after) abort_pend = 1'b1;
        end
      end
      @(posedge CLK); #1;
      h_we = 1'b0; h_addr = '0;
      cyc++;
      if (done) break;
    end
    pause = 1'b0; dp_ready = 1'b1;
    check_b("timeout", cyc < 500, 1'b1);
    check_i("row_count", idx, n);
    check_b("end_done", done, 1'b1);
    check_b("end_busy", busy, 1'b0);
    check_b("end_valid", dp_valid, 1'b0);
    check_b("end_h_busy", h_busy, 1'b0);
    check_i("end_epoch", int'(epoch_cnt), e);
    check_i("end_dp_cnt", int'(dp_cnt), 1);
  endtask

  initial begin
    int pulses, w;
    RST = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
    cfg_dp = '0; cfg_epoch = '0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    dp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int a = 0; a < 6; a++) host_write(a, rand_row());

    // Basic 3x2 run with ready held high.
    run_sched(3, 2, 1'b0, -1, -1, -1, -1);
    // Five-cycle back-pressure on data row 2.
    run_sched(3, 2, 1'b0, 2, -1, -1, -1);
    // Pause after row 1, rewrite row 2 while paused.
    run_sched(3, 1, 1'b0, -1, 1, -1, -1);
    // Host write attempted while the scheduler owns the RAM.
    run_sched(3, 2, 1'b0, -1, -1, 2, -1);
    check_w("hwe_mem_unchanged", mem[1], ref_mem[1]);
    // Abort mid-epoch, then a clean restart from the weight row.
    run_sched(3, 2, 1'b0, -1, -1, -1, 3);
    run_sched(3, 2, 1'b0, -1, -1, -1, -1);
    // Pause on the final handshake: completion wins.
    run_sched(2, 1, 1'b0, -1, 2, -1, -1);

    // Zero data points: straight to DONE, counters cleared.
    cfg_dp = '0; cfg_epoch = EW'(2); start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (dp_valid) pulses++;
      @(posedge CLK); #1;
    end
    check_i("zero_dp_pulses", pulses, 0);
    check_b("zero_dp_done", done, 1'b1);
    check_b("zero_dp_busy", busy, 1'b0);
    check_i("zero_dp_epoch", int'(epoch_cnt), 0);
    check_i("zero_dp_cnt", int'(dp_cnt), 0);

    // Zero epochs behaves the same way.
    run_sched(2, 1, 1'b0, -1, -1, -1, -1);
    cfg_dp = AW'(3); cfg_epoch = '0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    check_b("zero_ep_done", done, 1'b1);
    check_b("zero_ep_valid", dp_valid, 1'b0);
    check_i("zero_ep_epoch", int'(epoch_cnt), 0);

    // Randomised jobs with random back-pressure and refreshed data.
    for (int r = 0; r < 4; r++) begin
      int rd, re;
      rd = $urandom_range(1, 5);
      re = $urandom_range(1, 3);
      host_write($urandom_range(1, 5), rand_row());
      run_sched(rd, re, 1'b1, -1, -1, -1, -1);
    end

    // Synchronous reset while a data row is being offered.
    cfg_dp = AW'(3); cfg_epoch = EW'(1); dp_ready = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    w = 0;
    while (!(dp_valid && !dp_wload) && w < 50) begin
      @(posedge CLK); #1;
      w++;
    end
    check_b("rst_reach_rxfer", w < 50, 1'b1);
    dp_ready = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("rst_rxfer");
    RST = 1'b0;
    @(posedge CLK); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
